// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock detector and the code sender:
// FSM state encoding, the programmed code, and default timing constants.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    GAP      = 2'd2,
    WAIT_ACK = 2'd3
  } lock_state_e;

  localparam int                       LOCK_CODE_LEN   = 5;
  localparam logic [LOCK_CODE_LEN-1:0] LOCK_CODE       = 5'b11010;
  localparam int                       LOCK_GAP_CYCLES = 2;
  localparam int                       LOCK_TIMEOUT    = 4;
  localparam int                       LOCK_MAX_RETRY  = 3;

endpackage

// File: rtl/lock_cycle_counter.sv
// Loadable down-counter; tc flags the last cycle of a loaded interval
// (count == 1), so loading N yields exactly N enabled cycles.
module lock_cycle_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/lock_code_sender.sv
// Plays a programmed button code into the combination lock, waits for unlock,
// and retries the whole code a bounded number of times before reporting fail.
//
// Handshake: start is a level request sampled only in IDLE; unlock is sampled
// only in WAIT_ACK; done/fail are single-cycle pulses in the first IDLE cycle,
// during which a new start is already accepted.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN   = LOCK_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE       = LOCK_CODE,
  parameter int                  GAP_CYCLES = LOCK_GAP_CYCLES,
  parameter int                  TIMEOUT    = LOCK_TIMEOUT,
  parameter int                  MAX_RETRY  = LOCK_MAX_RETRY
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        unlock,
  output logic        button_0,
  output logic        button_1,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output lock_state_e state_dbg
);

  localparam int IDX_W   = $clog2(CODE_LEN) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]   TO_LOAD   = CNT_W'(TIMEOUT);
  localparam bit                 NO_GAP    = (GAP_CYCLES == 0);

  lock_state_e        state;
  logic [IDX_W-1:0]   idx;
  logic [RETRY_W-1:0] retry;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;
  logic             retry_now;

  // Returns {button_1, button_0} for code bit i.
  function automatic logic [1:0] press_of(input logic [IDX_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (i == IDX_W'(k)) b = CODE[k];
    end
    return {b, ~b};
  endfunction

  // The counter is loaded on the way into GAP or WAIT_ACK; unlock has
  // priority over a timeout landing in the same cycle.
  assign retry_now = (state == WAIT_ACK) && cnt_tc && !unlock && (retry < RETRY_LIM);
  assign cnt_load  = (state == PRESS) || retry_now;
  assign cnt_val   = ((state == PRESS) && (idx == '0)) ? TO_LOAD : GAP_LOAD;
  assign cnt_en    = (state == GAP) || (state == WAIT_ACK);

  lock_cycle_counter #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      retry    <= '0;
      button_0 <= 1'b0;
      button_1 <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      button_0 <= 1'b0;
      button_1 <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                <= PRESS;
            idx                  <= LAST_IDX;
            retry                <= '0;
            busy                 <= 1'b1;
            {button_1, button_0} <= press_of(LAST_IDX);
          end
        end
        PRESS: begin
          if (idx != '0) begin
            idx <= idx - 1'b1;
            if (NO_GAP) begin
              state                <= PRESS;
              {button_1, button_0} <= press_of(idx - 1'b1);
            end else begin
              state <= GAP;
            end
          end else begin
            state <= WAIT_ACK;
          end
        end
        GAP: begin
          if (cnt_tc) begin
            state                <= PRESS;
            {button_1, button_0} <= press_of(idx);
          end
        end
        WAIT_ACK: begin
          if (unlock) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt_tc) begin
            if (retry < RETRY_LIM) begin
              retry <= retry + 1'b1;
              idx   <= LAST_IDX;
              if (NO_GAP) begin
                state                <= PRESS;
                {button_1, button_0} <= press_of(LAST_IDX);
              end else begin
                state <= GAP;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: per-cycle output vectors
// {button_1, button_0, busy, done, fail} against hand-derived schedules.
module tb_lock_code_sender;
  import lock_pkg::*;

  // clock / reset
  logic clock;
  logic rst;
  logic start;
  logic unlock;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // DUT A: default parameters
  logic        a_b0, a_b1, a_busy, a_done, a_fail;
  lock_state_e a_state;

  lock_code_sender dut_a (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .unlock    (unlock),
    .button_0  (a_b0),
    .button_1  (a_b1),
    .busy      (a_busy),
    .done      (a_done),
    .fail      (a_fail),
    .state_dbg (a_state)
  );

  // DUT B: short code, no gap
  logic        b_b0, b_b1, b_busy, b_done, b_fail;
  lock_state_e b_state;

  lock_code_sender #(
    .CODE_LEN   (3),
    .CODE       (3'b101),
    .GAP_CYCLES (0)
  ) dut_b (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .unlock    (unlock),
    .button_0  (b_b0),
    .button_1  (b_b1),
    .busy      (b_busy),
    .done      (b_done),
    .fail      (b_fail),
    .state_dbg (b_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  logic [127:0] st_m, ul_m, rs_m;
  logic [127:0] e_b1, e_b0, e_busy, e_done, e_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] obs(input bit sel);
    if (sel) return {b_b1, b_b0, b_busy, b_done, b_fail};
    return {a_b1, a_b0, a_busy, a_done, a_fail};
  endfunction

  function automatic lock_state_e st_of(input bit sel);
    return sel ? b_state : a_state;
  endfunction

  // driver / expectation helpers
  task automatic clear_all();
    st_m = '0; ul_m = '0; rs_m = '0;
    e_b1 = '0; e_b0 = '0; e_busy = '0; e_done = '0; e_fail = '0;
  endtask

  task automatic mark(input int c, input bit b);
    if (b) e_b1[c] = 1'b1;
    else   e_b0[c] = 1'b1;
  endtask

  task automatic train(input int first, input logic [7:0] code, input int len, input int step);
    for (int j = 0; j < len; j++) mark(first + j * step, code[len - 1 - j]);
  endtask

  task automatic set_busy(input int a, input int b);
    for (int c = a; c <= b; c++) e_busy[c] = 1'b1;
  endtask

  // Reset, then cycles 0..n with masks driven; checks cycles 1..n+1.
  task automatic run(input string name, input bit sel, input int n);
    rst = 1'b1; start = 1'b0; unlock = 1'b0;
    tick();
    rst = 1'b0;
    check_eq({name, "_reset_out"}, 32'(obs(sel)), 32'd0);
    check_eq({name, "_reset_state"}, 32'(st_of(sel)), 32'(IDLE));
    for (int c = 1; c <= n + 1; c++)
      exp_q.push_back({e_b1[c], e_b0[c], e_busy[c], e_done[c], e_fail[c]});
    for (int c = 0; c <= n; c++) begin
      start  = st_m[c];
      unlock = ul_m[c];
      rst    = rs_m[c];
      tick();
      check_eq($sformatf("%s_c%0d", name, c + 1), 32'(obs(sel)), 32'(exp_q.pop_front()));
    end
    rst = 1'b0; start = 1'b0; unlock = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; unlock = 1'b0;

    // unlock on first attempt; starts while busy ignored; start on done cycle accepted
    clear_all();
    st_m[0] = 1; st_m[3] = 1; st_m[9] = 1; st_m[15] = 1;
    ul_m[5] = 1; ul_m[14] = 1; ul_m[29] = 1;
    train(1, 8'b11010, 5, 3);  set_busy(1, 14);  e_done[15] = 1;
    train(16, 8'b11010, 5, 3); set_busy(16, 29); e_done[30] = 1;
    run("dflt_done", 1'b0, 32);

    // unlock never arrives: four attempts then fail
    clear_all();
    st_m[0] = 1;
    train(1, 8'b11010, 5, 3);  train(20, 8'b11010, 5, 3);
    train(39, 8'b11010, 5, 3); train(58, 8'b11010, 5, 3);
    set_busy(1, 74); e_fail[75] = 1;
    run("dflt_fail", 1'b0, 80);

    // unlock on the last WAIT_ACK cycle of the second attempt
    clear_all();
    st_m[0] = 1; ul_m[36] = 1;
    train(1, 8'b11010, 5, 3); train(20, 8'b11010, 5, 3);
    set_busy(1, 36); e_done[37] = 1;
    run("dflt_retry", 1'b0, 42);

    // back-to-back presses; unlock during PRESS ignored, first WAIT_ACK cycle accepted
    clear_all();
    st_m[0] = 1; ul_m[2] = 1; ul_m[4] = 1;
    train(1, 8'b101, 3, 1); set_busy(1, 4); e_done[5] = 1;
    run("nogap_done", 1'b1, 8);

    // no gap, no unlock: retry goes straight back to PRESS
    clear_all();
    st_m[0] = 1;
    train(1, 8'b101, 3, 1);  train(8, 8'b101, 3, 1);
    train(15, 8'b101, 3, 1); train(22, 8'b101, 3, 1);
    set_busy(1, 28); e_fail[29] = 1;
    run("nogap_fail", 1'b1, 32);

    // reset mid-gap, then restart from the first bit
    clear_all();
    st_m[0] = 1; rs_m[8] = 1; st_m[10] = 1; st_m[15] = 1; ul_m[24] = 1;
    mark(1, 1'b1); mark(4, 1'b1); mark(7, 1'b0); set_busy(1, 8);
    train(11, 8'b11010, 5, 3); set_busy(11, 24); e_done[25] = 1;
    run("rst_mid", 1'b0, 28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmit-side counterpart of the team's combination-lock detector.
- On request, plays a programmed code onto the lock's button_0/button_1 inputs as one-cycle presses separated by idle gaps, then waits for the lock's unlock indication.
- If unlock does not arrive, it retries the whole code a bounded number of times.
- Sits between system control logic (start/done/fail) and the lock's button interface.

Parameters:
- CODE_LEN, 5, number of presses in the code; must be >= 1.
- CODE, 5'b11010, press sequence sent MSB first; bit=1 means a button_1 press, bit=0 means a button_0 press.
- GAP_CYCLES, 2, idle cycles (both buttons low) between presses; 0 allowed.
- TIMEOUT, 4, cycles spent waiting for unlock per attempt; must be >= 1.
- MAX_RETRY, 3, extra attempts after the first before fail.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to send the code; sampled only in IDLE.
- unlock  in  1  lock response; sampled only in WAIT_ACK.
- button_0  out  1  registered one-cycle press pulse for code bit 0.
- button_1  out  1  registered one-cycle press pulse for code bit 1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: unlock received.
- fail  out  1  one-cycle pulse: retries exhausted.

Behaviour:
- Reset: rst high at an edge forces state IDLE and clears all counters. In the next cycle button_0, button_1, busy, done and fail are all 0. Applies mid-operation with no partial completion pulse.
- States: IDLE, PRESS, GAP, WAIT_ACK.
- IDLE: start=1 -> PRESS with bit index = CODE_LEN-1 and retry count = 0. start is ignored in every other state.
- PRESS: lasts exactly 1 cycle. button_1=CODE[idx] and button_0=~CODE[idx]; never both high; both low in every other state.
- After PRESS:
  - If idx > 0: decrement idx, then GAP, or straight to PRESS when GAP_CYCLES=0.
  - If idx = 0: WAIT_ACK.
- GAP: exactly GAP_CYCLES cycles, then PRESS.
- WAIT_ACK: at most TIMEOUT cycles.
  - unlock=1 in any WAIT_ACK cycle -> IDLE, with done=1 in the first IDLE cycle.
  - On the last WAIT_ACK cycle with unlock=0:
    - If retry < MAX_RETRY: retry++, idx = CODE_LEN-1, then GAP (or PRESS when GAP_CYCLES=0).
    - Otherwise -> IDLE, with fail=1 in the first IDLE cycle.
- Simultaneous unlock and timeout in the same cycle: unlock wins (done).
- done/fail cycle: busy=0, and start in that same cycle is accepted.
- Latency, default parameters:
  - start sampled in cycle 0 -> presses in cycles 1, 4, 7, 10, 13.
  - WAIT_ACK runs cycles 14..17.
  - Retry first press at cycle 20; attempt k first press at cycle 1+19k.
- Counter widths: idx $clog2(CODE_LEN)+1; gap/timeout counter wide enough for max(GAP_CYCLES, TIMEOUT); retry $clog2(MAX_RETRY+1)+1. No wrap is reachable.

Decomposition:
- Shared package lock_pkg holds:
  - state enum typedef (IDLE, PRESS, GAP, WAIT_ACK);
  - LOCK_CODE = 5'b11010 and LOCK_CODE_LEN = 5, used both as this block's defaults and by the detector;
  - default GAP/TIMEOUT constants.
- One sub-module, lock_cycle_counter: loadable down-counter with terminal-count flag, shared by the GAP and WAIT_ACK timing.

Test Plan:
- Defaults, paired with the lock detector; start pulse in cycle 0 -> button_1 in cycles 1 and 4, button_0 in 7, button_1 in 10, button_0 in 13; unlock seen in 14; done=1 in cycle 15; busy high cycles 1-14.
- Defaults, unlock tied 0 -> 4 identical press trains starting cycles 1, 20, 39, 58; fail=1 in cycle 75 only; done never asserted.
- Unlock held 0 until the 2nd attempt's WAIT_ACK, then forced 1 on its last cycle (cycle 36) -> done=1 in cycle 37; no fail; exactly 2 press trains.
- GAP_CYCLES=0, CODE=3'b101, CODE_LEN=3 -> presses back-to-back in cycles 1, 2, 3 (b1, b0, b1); WAIT_ACK starts cycle 4.
- rst asserted in cycle 8 mid-gap -> all outputs 0 from cycle 9; start in cycle 10 restarts from first bit (press in cycle 11); extra start pulses while busy produce no change.
- unlock pulsed while in PRESS/GAP (cycle 5) -> ignored; the sequence completes normally.
